// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data memory bus interface between the load/store unit and memory
`timescale 1ns/1ps
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit; LSU_MISALIGN_TRAP_EN enables misaligned-access fault
`timescale 1ns/1ps
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lsu_req,
  input  logic               lsu_we,
  input  logic [1:0]         lsu_size,
  input  logic [ADDR_W-1:0]  lsu_addr,
  input  logic [31:0]        lsu_wdata,
  output logic [31:0]        lsu_rdata,
  output logic               lsu_stall,
  output logic               lsu_fault,
  load_store_unit_if.master  mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              take_req;
  logic              trap;
  logic [1:0]        offset;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;

  logic              we_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        off_q;

  // Lane decode with forced alignment: half drops bit 0, word drops bits 1:0
  always_comb begin
    offset    = lsu_addr[1:0];
    be        = 4'b0001 << lsu_addr[1:0];
    wdata_rep = {4{lsu_wdata[7:0]}};
    case (lsu_size)
      2'b00: begin
        offset    = lsu_addr[1:0];
        be        = 4'b0001 << lsu_addr[1:0];
        wdata_rep = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        offset    = {lsu_addr[1], 1'b0};
        be        = 4'b0011 << {lsu_addr[1], 1'b0};
        wdata_rep = {2{lsu_wdata[15:0]}};
      end
      default: begin
        offset    = 2'b00;
        be        = 4'b1111;
        wdata_rep = lsu_wdata;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = (lsu_size == 2'b01) ? lsu_addr[0]
              : (lsu_size[1] ? (|lsu_addr[1:0]) : 1'b0);
`else
  assign trap = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a trapped access skips the bus and goes straight to DONE
  always_comb begin
    state_nxt = state;
    take_req  = 1'b0;
    unique case (state)
      IDLE: begin
        if (lsu_req) begin
          if (trap) begin
            state_nxt = DONE;
          end else begin
            state_nxt = BUS;
            take_req  = 1'b1;
          end
        end
      end
      BUS:     if (mem.mem_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch request fields on issue; capture shifted load data on handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q      <= 1'b0;
      be_q      <= 4'b0000;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      off_q     <= 2'b00;
      lsu_rdata <= 32'h0;
    end else begin
      if (take_req) begin
        we_q    <= lsu_we;
        be_q    <= be;
        addr_q  <= {lsu_addr[ADDR_W-1:2], 2'b00};
        wdata_q <= wdata_rep;
        off_q   <= offset;
      end
      if ((state == BUS) && mem.mem_ready && !we_q) begin
        lsu_rdata <= mem.mem_rdata >> {off_q, 3'b000};
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Fault is high for exactly the DONE cycle that follows a trapped request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lsu_fault <= 1'b0;
    else        lsu_fault <= (state == IDLE) && lsu_req && trap;
  end
`else
  assign lsu_fault = 1'b0;
`endif

  // Valid is derived from state so an asynchronous reset retracts it at once
  assign mem.mem_valid = (state == BUS);
  assign mem.mem_we    = we_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign lsu_stall = reset && lsu_req && (state != DONE);

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard testbench for load_store_unit
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_req;
  logic        lsu_we;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_rdata;
  logic        lsu_stall;
  logic        lsu_fault;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .lsu_req   (lsu_req),
    .lsu_we    (lsu_we),
    .lsu_size  (lsu_size),
    .lsu_addr  (lsu_addr),
    .lsu_wdata (lsu_wdata),
    .lsu_rdata (lsu_rdata),
    .lsu_stall (lsu_stall),
    .lsu_fault (lsu_fault),
    .mem       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          vcyc;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } resp_exp_t;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];
  int        n_checks = 0;
  int        n_fail   = 0;
  int        wait_left = 0;
  int        valid_cnt = 0;
  resp_exp_t mon_r;
  bus_exp_t  rst_b;

  function automatic void check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Memory responder: holds ready low for wait_left valid cycles, then accepts
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_valid && wait_left > 0) begin
        bus.mem_ready = 1'b0;
        wait_left--;
      end else begin
        bus.mem_ready = bus.mem_valid;
      end
    end
  end

  // Monitor: compares bus fields every valid cycle and the response at DONE
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        valid_cnt = 0;
      end else begin
        if (bus.mem_valid) begin
          valid_cnt++;
          check32("bus_txn_expected", bus_q.size() > 0, 1);
          if (bus_q.size() > 0) begin
            check32("mem_we", bus.mem_we, bus_q[0].we);
            check32("mem_addr", bus.mem_addr, bus_q[0].addr);
            check32("mem_be", bus.mem_be, bus_q[0].be);
            check32("mem_wdata", bus.mem_wdata, bus_q[0].wdata);
            if (bus.mem_ready) begin
              check32("valid_cycles", valid_cnt, bus_q[0].vcyc);
              void'(bus_q.pop_front());
              valid_cnt = 0;
            end
          end
        end
        if (lsu_req && !lsu_stall) begin
          check32("bus_drained_at_done", bus_q.size(), 0);
          check32("resp_expected", resp_q.size() > 0, 1);
          if (resp_q.size() > 0) begin
            mon_r = resp_q.pop_front();
            check32("lsu_rdata", lsu_rdata, mon_r.rdata);
            check32("lsu_fault_done", lsu_fault, mon_r.fault);
          end
        end else begin
          check32("lsu_fault_idle", lsu_fault, 0);
        end
      end
    end
  end

  // One access, started at posedge+1 while the unit is in IDLE
  task automatic do_access(input string tag, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] mrdata, input int waits,
                           input logic exp_bus, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_rdata, input logic exp_fault,
                           input int exp_stall);
    bus_exp_t  b;
    resp_exp_t r;
    int        stalls;
    int        first_valid;
    logic      done;
    if (exp_bus) begin
      b.we = we; b.addr = exp_addr; b.be = exp_be; b.wdata = exp_wdata; b.vcyc = waits + 1;
      bus_q.push_back(b);
    end
    r.rdata = exp_rdata;
    r.fault = exp_fault;
    resp_q.push_back(r);
    wait_left     = waits;
    bus.mem_rdata = mrdata;
    lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_wdata = wdata; lsu_req = 1'b1;
    stalls = 0; first_valid = -1; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.mem_valid && first_valid < 0) first_valid = i;
      if (lsu_stall) stalls++;
      else done = 1'b1;
    end
    check32({tag, "_completed"}, done, 1);
    check32({tag, "_stall_cycles"}, stalls, exp_stall);
    check32({tag, "_first_valid"}, first_valid, exp_bus ? 1 : -1);
    @(posedge clk);
    #1;
    lsu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = 2'b00;
    lsu_addr = 32'h0; lsu_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    lsu_req = 1'b1;
    #1;
    check32("rst_mem_valid", bus.mem_valid, 0);
    check32("rst_mem_we", bus.mem_we, 0);
    check32("rst_mem_be", bus.mem_be, 0);
    check32("rst_mem_addr", bus.mem_addr, 0);
    check32("rst_mem_wdata", bus.mem_wdata, 0);
    check32("rst_lsu_rdata", lsu_rdata, 0);
    check32("rst_lsu_fault", lsu_fault, 0);
    check32("rst_lsu_stall", lsu_stall, 0);
    lsu_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    do_access("ld_word", 1'b0, 2'b10, 32'h100, 32'h0, 32'hDEADBEEF, 0,
              1'b1, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    do_access("st_byte", 1'b1, 2'b00, 32'h203, 32'h000000A5, 32'h0, 0,
              1'b1, 32'h200, 4'b1000, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 2);
    do_access("ld_half_wait", 1'b0, 2'b01, 32'h302, 32'h0, 32'h1234ABCD, 3,
              1'b1, 32'h300, 4'b1100, 32'h0, 32'h00001234, 1'b0, 5);
`ifdef LSU_MISALIGN_TRAP_EN
    do_access("ld_word_mis", 1'b0, 2'b10, 32'h101, 32'h0, 32'hCAFEF00D, 0,
              1'b0, 32'h0, 4'b0000, 32'h0, 32'h00001234, 1'b1, 1);
`else
    do_access("ld_word_mis", 1'b0, 2'b10, 32'h101, 32'h0, 32'hCAFEF00D, 0,
              1'b1, 32'h100, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0, 2);
`endif
    do_access("ld_byte1", 1'b0, 2'b00, 32'h101, 32'h0, 32'h11223344, 0,
              1'b1, 32'h100, 4'b0010, 32'h0, 32'h00112233, 1'b0, 2);
    do_access("st_half", 1'b1, 2'b01, 32'h006, 32'h0000BEEF, 32'h0, 1,
              1'b1, 32'h004, 4'b1100, 32'hBEEFBEEF, 32'h00112233, 1'b0, 3);
    do_access("b2b_st", 1'b1, 2'b10, 32'h010, 32'h89ABCDEF, 32'h0, 0,
              1'b1, 32'h010, 4'b1111, 32'h89ABCDEF, 32'h00112233, 1'b0, 2);
    do_access("b2b_ld", 1'b0, 2'b10, 32'h010, 32'h0, 32'h55AA55AA, 0,
              1'b1, 32'h010, 4'b1111, 32'h0, 32'h55AA55AA, 1'b0, 2);
    do_access("ld_size3", 1'b0, 2'b11, 32'h020, 32'h0, 32'h0BADF00D, 0,
              1'b1, 32'h020, 4'b1111, 32'h0, 32'h0BADF00D, 1'b0, 2);

    rst_b.we = 1'b0; rst_b.addr = 32'h400; rst_b.be = 4'b1111; rst_b.wdata = 32'h0; rst_b.vcyc = 0;
    bus_q.push_back(rst_b);
    wait_left = 5;
    bus.mem_rdata = 32'h77777777;
    lsu_we = 1'b0; lsu_size = 2'b10; lsu_addr = 32'h400; lsu_wdata = 32'h0; lsu_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check32("rst_bus_pre_valid", bus.mem_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check32("rst_bus_valid_drop", bus.mem_valid, 0);
    check32("rst_bus_mem_be", bus.mem_be, 0);
    check32("rst_bus_mem_addr", bus.mem_addr, 0);
    check32("rst_bus_lsu_rdata", lsu_rdata, 0);
    check32("rst_bus_lsu_stall", lsu_stall, 0);
    bus_q.delete();
    resp_q.delete();
    wait_left = 0;
    @(posedge clk);
    #1;
    lsu_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check32("post_rst_mem_valid", bus.mem_valid, 0);
    check32("post_rst_mem_wdata", bus.mem_wdata, 0);
    do_access("post_rst_ld_byte3", 1'b0, 2'b00, 32'h003, 32'h0, 32'hA1B2C3D4, 0,
              1'b1, 32'h000, 4'b1000, 32'h0, 32'h000000A1, 1'b0, 2);

    repeat (3) @(posedge clk);
    #1;
    check32("final_bus_q_empty", bus_q.size(), 0);
    check32("final_resp_q_empty", resp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
